instr_encode_writer: RTL and testbench

- Inverse of the instruction field decoder: takes RISC-V RV32I fields plus a format code and packs them into a 32-bit instruction word.
- Writes each packed word sequentially into instruction memory through a write/ack handshake.
- Used by the program-load and self-test path to fill imem before the core is released from reset.
- Immediate inputs use the decoder's field ordering, so decoded fields re-encode to the original word.

---
 rtl/instr_encode_writer.sv | 101 ++++++++++
 tb/tb_instr_encode_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_writer.sv
// Packs RV32I instruction fields into 32-bit words and streams them into
// instruction memory through a write/ack handshake.
module instr_encode_writer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   fmt,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [19:0]                  imm,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_wr_ack,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         done,
  output logic                         fmt_err
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_WRITE, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     packed_word;
  logic            fmt_legal;
  logic [CW-1:0]   count_inc;
  logic            last_word;

  // Immediate bit ordering follows the field decoder so decode/encode round-trips.
  always_comb begin
    packed_word = '0;
    fmt_legal   = 1'b1;
    case (fmt)
      3'd0: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: packed_word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      3'd4: packed_word = {imm[19:0], rd, opcode};
      3'd5: packed_word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
      default: fmt_legal = 1'b0;
    endcase
  end

  assign count_inc = count + 1'b1;
  assign last_word = (count_inc == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READY;
      S_READY: begin
        if (start)                     state_nxt = S_READY;
        else if (in_valid && fmt_legal) state_nxt = S_WRITE;
      end
      S_WRITE: if (mem_wr_ack) state_nxt = last_word ? S_DONE : S_READY;
      S_DONE:  if (start) state_nxt = S_READY;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_READY);
  assign mem_wr_en = (state == S_WRITE);
  assign done      = (state == S_DONE);

  // start re-arms in every state except WRITE, where the pending write finishes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      count     <= '0;
      fmt_err   <= 1'b0;
    end else if (start && state != S_WRITE) begin
      mem_addr <= ADDR_W'(BASE_ADDR);
      count    <= '0;
      fmt_err  <= 1'b0;
    end else if (state == S_READY && in_valid) begin
      if (fmt_legal) mem_wdata <= packed_word;
      else           fmt_err   <= 1'b1;
    end else if (state == S_WRITE && mem_wr_ack) begin
      mem_addr <= mem_addr + ADDR_W'(4);
      count    <= count_inc;
    end
  end

endmodule

// File: tb/tb_instr_encode_writer.sv
// Scoreboard bench for instr_encode_writer: directed field bundles with
// hand-computed words; a monitor checks every memory write it observes.
module tb_instr_encode_writer;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BASE_ADDR = 8;
  localparam int unsigned DEPTH     = 2;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [19:0] imm;
  logic        mem_wr_en, mem_wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  count;
  logic        done, fmt_err;

  logic        resp_ack = 1'b0;
  logic        ack_force = 1'b0;
  int unsigned ack_delay = 0;
  assign mem_wr_ack = resp_ack | ack_force;

  instr_encode_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack), .count(count), .done(done),
    .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cnt;
    int unsigned cyc;
    bit          abandon;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit have = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d,
                           input int unsigned c, input int unsigned cy, input bit ab);
    item_t it;
    it.addr = a; it.data = d; it.cnt = c; it.cyc = cy; it.abandon = ab;
    q.push_back(it);
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [19:0] im);
    int unsigned w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      chk("send_wait_ready", 64'(in_ready), 64'd1);
    end else begin
      fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int unsigned w = 0;
    @(negedge clk);
    while ((q.size() != 0 || have || mem_wr_en !== 1'b0) && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0 || have) chk("write_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Memory responder: asserts ack after ack_delay cycles of mem_wr_en.
  initial begin
    int unsigned wc = 0;
    forever begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) begin
        resp_ack = (wc >= ack_delay);
        wc++;
      end else begin
        resp_ack = 1'b0;
        wc = 0;
      end
    end
  end

  // Monitor: pops an expected write on each rising mem_wr_en and tracks the hold.
  initial begin
    item_t cur;
    bit prev = 1'b0;
    int unsigned cyc = 0;
    forever begin
      @(negedge clk);
      if (mem_wr_en === 1'b1 && !prev) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 64'(mem_wdata), 64'hDEAD_0000_0000);
        end else begin
          cur = q.pop_front();
          have = 1'b1;
          cyc = 1;
          chk("wr_addr", 64'(mem_addr), 64'(cur.addr));
          chk("wr_data", 64'(mem_wdata), 64'(cur.data));
          chk("ready_during_write", 64'(in_ready), 64'd0);
        end
      end else if (mem_wr_en === 1'b1 && prev && have) begin
        cyc++;
        chk("hold_addr_data", {28'(mem_addr), mem_wdata}, {28'(cur.addr), cur.data});
        chk("ready_during_write", 64'(in_ready), 64'd0);
      end else if (mem_wr_en !== 1'b1 && prev && have) begin
        chk("count_after_write", 64'(count), 64'(cur.cnt));
        if (!cur.abandon) chk("wr_en_cycles", 64'(cyc), 64'(cur.cyc));
        have = 1'b0;
      end
      prev = (mem_wr_en === 1'b1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'(BASE_ADDR));
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done_err", {done, fmt_err}, 64'd0);

    pulse_start();
    @(negedge clk);
    chk("start_ready", 64'(in_ready), 64'd1);

    // R then I, immediate ack; second write reaches DEPTH and address wraps
    expect_wr(32'h8, 32'h002081B3, 1, 1, 1'b0);
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 20'h0);
    wait_idle();
    chk("r_count", 64'(count), 64'd1);
    chk("r_ready_again", 64'(in_ready), 64'd1);
    expect_wr(32'hC, 32'hFFF00293, 2, 1, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 20'hFFF);
    wait_idle();
    chk("done_set", {done, in_ready}, 64'b10);
    chk("addr_wrap", 64'(mem_addr), 64'd0);

    // bundles offered while done must be ignored
    @(negedge clk);
    in_valid = 1'b1; fmt = 3'd4; opcode = 7'h37; rd = 5'd9; imm = 20'hABCDE;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("done_ignores", {mem_wr_en, 2'(count), done}, {1'b0, 2'd2, 1'b1});

    pulse_start();
    @(negedge clk);
    chk("restart", {27'(mem_addr), 2'(count), done, in_ready}, {27'(BASE_ADDR), 2'd0, 1'b0, 1'b1});

    expect_wr(32'h8, 32'h123450B7, 1, 1, 1'b0);
    send(3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 20'h12345);
    expect_wr(32'hC, 32'h0080006F, 2, 1, 1'b0);
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 20'h00004);
    wait_idle();
    chk("uj_done", 64'(done), 64'd1);

    // delayed ack: wr_en held 4 cycles, single count increment
    pulse_start();
    ack_delay = 3;
    expect_wr(32'h8, 32'h00208463, 1, 4, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 20'h004);
    wait_idle();
    ack_delay = 0;

    // ack with no pending write has no effect
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    chk("stray_ack", {27'(mem_addr), 2'(count), mem_wr_en}, {27'hC, 2'd1, 1'b0});

    // illegal format: no write, sticky error until start
    send(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 20'h0);
    @(negedge clk);
    chk("fmt6_err", {fmt_err, mem_wr_en, in_ready, 2'(count)}, {1'b1, 1'b0, 1'b1, 2'd1});
    expect_wr(32'hC, 32'h403100B3, 2, 1, 1'b0);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 20'h0);
    wait_idle();
    chk("fmt_err_sticky", {fmt_err, done}, 64'b11);
    pulse_start();
    @(negedge clk);
    chk("fmt_err_cleared", 64'(fmt_err), 64'd0);

    // S format with unused rd/funct7 driven to junk
    expect_wr(32'h8, 32'h7E512C23, 1, 1, 1'b0);
    send(3'd2, 7'h23, 3'd2, 7'h7F, 5'd31, 5'd2, 5'd5, 20'hFF7F8);
    wait_idle();

    // reset mid-write, with start and ack in the same cycle
    ack_delay = 100;
    expect_wr(32'hC, 32'h12308113, 0, 0, 1'b1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd1, 5'd0, 20'h00123);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; ack_force = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0; ack_force = 1'b0;
    @(negedge clk);
    chk("rst_mid_write", {mem_wr_en, in_ready, 2'(count), done}, {1'b0, 1'b0, 2'd0, 1'b0});
    chk("rst_mid_addr", 64'(mem_addr), 64'(BASE_ADDR));
    @(negedge clk);
    chk("rst_stays_idle", 64'(in_ready), 64'd0);
    ack_delay = 0;
    pulse_start();
    @(negedge clk);
    chk("post_rst_start", 64'(in_ready), 64'd1);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
